// File: rtl/matrix_kxk_window.sv
// matrix_kxk_window: streams raster pixels through K-1 line buffers and a
// KxK register array. It presents the full sliding window for every accepted
// pixel and flags the windows that lie entirely inside the image.
module matrix_kxk_window #(
  parameter int DATA_W = 10,
  parameter int K      = 3,
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic                  valid_in,
  input  logic                  frame_clr,
  output logic [K*K*DATA_W-1:0] win,
  output logic                  win_valid,
  output logic [CNT_W-1:0]      win_col,
  output logic [CNT_W-1:0]      win_row,
  output logic                  frame_done
);

  localparam int NLB = K - 1;
  localparam int AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] EDGE_MIN = CNT_W'(K - 1);

  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [AW-1:0]     col_idx;
  logic              accept;
  logic [DATA_W-1:0] lb_rd   [NLB];
  logic [DATA_W-1:0] new_col [K];
  logic [DATA_W-1:0] win_reg [K][K];

  // A frame restart takes priority over a pixel presented on the same edge.
  assign accept  = valid_in && !frame_clr;
  assign col_idx = col[AW-1:0];

  // Line-buffer chain: buffer 0 holds the previous line and the last buffer
  // holds the oldest. Each buffer is read before it is written at the same
  // column, so on acceptance every line moves one buffer deeper.
  generate
    for (genvar gi = 0; gi < NLB; gi++) begin : g_lb
      logic [DATA_W-1:0] mem [IMG_W];
      assign lb_rd[gi] = mem[col_idx];
      if (gi == 0) begin : g_first
        // Newest line buffer captures the incoming pixel.
        always_ff @(posedge clk) begin
          if (accept) mem[col_idx] <= din;
        end
      end else begin : g_rest
        // Deeper buffers take the line from the buffer in front of them.
        always_ff @(posedge clk) begin
          if (accept) mem[col_idx] <= lb_rd[gi-1];
        end
      end
    end
  endgenerate

  // New rightmost column: oldest line at row 0, incoming pixel at row K-1.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_newcol
      if (gi == K - 1) begin : g_cur
        assign new_col[gi] = din;
      end else begin : g_old
        assign new_col[gi] = lb_rd[K-2-gi];
      end
    end
  endgenerate

  // Window register array: shift every row left and load the new column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_reg[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_reg[r][c] <= win_reg[r][c+1];
        win_reg[r][K-1] <= new_col[r];
      end
    end
  end

  // Flatten the window: element (r,c) sits at bit offset (r*K+c)*DATA_W.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_pack_r
      for (genvar gj = 0; gj < K; gj++) begin : g_pack_c
        assign win[(gi*K+gj)*DATA_W +: DATA_W] = win_reg[gi][gj];
      end
    end
  endgenerate

  // Raster counters, output coordinates, window-valid flag and frame-end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_col    <= '0;
      win_row    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_clr) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (valid_in) begin
      win_col    <= col;
      win_row    <= row;
      // Windows that straddle a line wrap have col < K-1 and are never valid.
      win_valid  <= (row >= EDGE_MIN) && (col >= EDGE_MIN);
      frame_done <= (row == ROW_LAST) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
